// File: rtl/wb_mem_arb.sv
// -----------------------------------------------------------------------------
// wb_mem_arb
// Two-master Wishbone arbiter in front of a single memory slave.
// m0 (CPU) and m1 (secondary master) compete for the slave. A tie in IDLE is
// broken round robin. Once a master is granted, it keeps the slave until one
// of three events occurs:
//   - a classic or end-of-burst acknowledge,
//   - the master aborts by dropping stb,
//   - the slave fails to acknowledge within TMO cycles.
// On a timeout the owner receives a synthetic acknowledge with all-ones read
// data, and the sticky tmo_o flag is set.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   mX_adr/dat/sel/we_i    master X request fields
//   mX_stb_i               master X request (also acts as cyc)
//   mX_cti_i               master X cycle type (000 classic, 010 burst, 111 end)
//   mX_ack_o               acknowledge to master X (owner only)
//   m_dat_o                read data broadcast to both masters
//   s_*_o                  request fields of the granted master toward the slave
//   s_ack_i, s_dat_i       slave acknowledge and read data
//   owner_o, busy_o        current grant (valid while busy_o) and GNT indicator
//   tmo_o, tmo_clr_i       sticky timeout flag and its synchronous clear
// -----------------------------------------------------------------------------
module wb_mem_arb #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_stb_i,
    input  logic [2:0]      m0_cti_i,
    output logic            m0_ack_o,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_stb_i,
    input  logic [2:0]      m1_cti_i,
    output logic            m1_ack_o,
    output logic [DW-1:0]   m_dat_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic [2:0]      s_cti_o,
    output logic            s_stb_o,
    input  logic            s_ack_i,
    input  logic [DW-1:0]   s_dat_i,
    output logic            owner_o,
    output logic            busy_o,
    output logic            tmo_o,
    input  logic            tmo_clr_i
);

    typedef enum logic {
        IDLE = 1'b0,
        GNT  = 1'b1
    } state_t;

    // Count value at which the slave is declared dead.
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
    localparam logic [2:0] CTI_INCR = 3'b010;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q,  last_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       tmo_q,   tmo_d;

    logic       busy;
    logic       sel_m1;
    logic       own_stb;
    logic [2:0] own_cti;
    logic       tmo_hit;
    logic       rel;

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;   // m0 wins the first tie
            cnt_q   <= 8'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave a value unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = 8'd0;
        tmo_d    = tmo_q;

        busy     = (state_q == GNT);
        // The slave-side mux follows m0 whenever the bus is idle.
        sel_m1   = busy & owner_q;
        own_stb  = owner_q ? m1_stb_i : m0_stb_i;
        own_cti  = owner_q ? m1_cti_i : m0_cti_i;
        tmo_hit  = busy && (cnt_q == TMO_LAST);
        rel      = (s_ack_i && (own_cti != CTI_INCR)) || !own_stb || tmo_hit;

        s_adr_o  = sel_m1 ? m1_adr_i : m0_adr_i;
        s_dat_o  = sel_m1 ? m1_dat_i : m0_dat_i;
        s_sel_o  = sel_m1 ? m1_sel_i : m0_sel_i;
        s_we_o   = sel_m1 ? m1_we_i  : m0_we_i;
        s_cti_o  = sel_m1 ? m1_cti_i : m0_cti_i;
        s_stb_o  = busy & own_stb & ~tmo_hit;
        // A timeout completes the owner's cycle with a synthetic ack.
        m0_ack_o = busy & ~owner_q & (s_ack_i | tmo_hit);
        m1_ack_o = busy &  owner_q & (s_ack_i | tmo_hit);
        m_dat_o  = tmo_hit ? {DW{1'b1}} : s_dat_i;
        busy_o   = busy;
        owner_o  = owner_q;
        tmo_o    = tmo_q;

        // Set has priority over clear.
        if (tmo_hit) begin
            tmo_d = 1'b1;
        end else if (tmo_clr_i) begin
            tmo_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (m0_stb_i || m1_stb_i) begin
                    // Tie: grant whoever was not granted last time.
                    owner_d = (m0_stb_i && m1_stb_i) ? ~last_q : m1_stb_i;
                    last_d  = owner_d;
                    state_d = GNT;
                end
            end
            GNT: begin
                if (rel) begin
                    state_d = IDLE;
                end else if (!s_ack_i) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_mem_arb.sv
module tb_wb_mem_arb;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   m0_adr = '0, m1_adr = '0;
    logic [DW-1:0]   m0_dat = '0, m1_dat = '0;
    logic [DW/8-1:0] m0_sel = '1, m1_sel = '1;
    logic            m0_we = 1'b0, m1_we = 1'b0;
    logic            m0_stb = 1'b0, m1_stb = 1'b0;
    logic [2:0]      m0_cti = 3'b000, m1_cti = 3'b000;
    logic            m0_ack, m1_ack;
    logic [DW-1:0]   m_dat;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat;
    logic [DW/8-1:0] s_sel;
    logic            s_we;
    logic [2:0]      s_cti;
    logic            s_stb;
    logic            s_ack = 1'b0;
    logic [DW-1:0]   s_rdat = '0;
    logic            owner, busy, tmo;
    logic            tmo_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    wb_mem_arb #(.AW(AW), .DW(DW), .TMO(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_stb_i(m0_stb), .m0_cti_i(m0_cti), .m0_ack_o(m0_ack),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_stb_i(m1_stb), .m1_cti_i(m1_cti), .m1_ack_o(m1_ack),
        .m_dat_o(m_dat),
        .s_adr_o(s_adr), .s_dat_o(s_dat), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_cti_o(s_cti), .s_stb_o(s_stb), .s_ack_i(s_ack), .s_dat_i(s_rdat),
        .owner_o(owner), .busy_o(busy), .tmo_o(tmo), .tmo_clr_i(tmo_clr)
    );

    always #5 clk = ~clk;

    // One cycle of the round-robin table: inputs held for the cycle and the
    // outputs expected during that same cycle.
    typedef struct packed {
        logic m0_stb;
        logic m1_stb;
        logic s_ack;
        logic busy;
        logic owner;
        logic s_stb;
        logic m0_ack;
        logic m1_ack;
    } vec_t;

    vec_t       vecs [14];
    logic [2:0] burst_cti [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Both masters request continuously, each completing 3 classic
        // accesses; the slave acks as soon as it is strobed.
        //           m0 m1 ack busy own stb a0 a1
        vecs[0]  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[8]  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[12] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        burst_cti[0] = 3'b010;
        burst_cti[1] = 3'b010;
        burst_cti[2] = 3'b010;
        burst_cti[3] = 3'b111;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #2;
        check("rst busy",  32'(busy),   32'd0);
        check("rst s_stb", 32'(s_stb),  32'd0);
        check("rst m0ack", 32'(m0_ack), 32'd0);
        check("rst m1ack", 32'(m1_ack), 32'd0);
        check("rst tmo",   32'(tmo),    32'd0);
        check("rst owner", 32'(owner),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- round-robin tie table ----------------
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            m0_stb = vecs[i].m0_stb;
            m1_stb = vecs[i].m1_stb;
            s_ack  = vecs[i].s_ack;
            #2;
            check($sformatf("tie[%0d] busy", i),  32'(busy),   32'(vecs[i].busy));
            check($sformatf("tie[%0d] s_stb", i), 32'(s_stb),  32'(vecs[i].s_stb));
            check($sformatf("tie[%0d] m0ack", i), 32'(m0_ack), 32'(vecs[i].m0_ack));
            check($sformatf("tie[%0d] m1ack", i), 32'(m1_ack), 32'(vecs[i].m1_ack));
            if (vecs[i].busy)
                check($sformatf("tie[%0d] owner", i), 32'(owner), 32'(vecs[i].owner));
        end
        s_ack = 1'b0;

        // ---------------- single classic read by m0 ----------------
        @(negedge clk);
        m0_adr = 32'h000F_F004; m0_we = 1'b0; m0_cti = 3'b000; m0_stb = 1'b1;
        m1_adr = 32'hAAAA_0000;
        #2;
        check("single idle s_stb", 32'(s_stb), 32'd0);
        check("single idle s_adr", s_adr, 32'h000F_F004);
        @(negedge clk); #2;
        check("single N+1 s_stb", 32'(s_stb), 32'd1);
        check("single N+1 owner", 32'(owner), 32'd0);
        check("single N+1 s_adr", s_adr, 32'h000F_F004);
        @(negedge clk); #2;
        check("single wait s_stb", 32'(s_stb), 32'd1);
        check("single wait m0ack", 32'(m0_ack), 32'd0);
        @(negedge clk);
        s_ack = 1'b1; s_rdat = 32'h1234_5678;
        #2;
        check("single m0ack", 32'(m0_ack), 32'd1);
        check("single m1ack", 32'(m1_ack), 32'd0);
        check("single m_dat", m_dat, 32'h1234_5678);
        @(negedge clk);
        s_ack = 1'b0; m0_stb = 1'b0;
        #2;
        check("single done busy",  32'(busy),   32'd0);
        check("single done m0ack", 32'(m0_ack), 32'd0);

        // ---------------- m1 burst while m0 waits ----------------
        @(negedge clk);
        m1_adr = 32'h0000_2000; m1_dat = 32'hCAFE_0001; m1_we = 1'b1;
        m1_cti = 3'b010; m1_stb = 1'b1;
        #2;
        check("burst idle busy", 32'(busy), 32'd0);
        @(negedge clk);
        m0_stb = 1'b1; m0_cti = 3'b000;
        #2;
        check("burst gnt owner", 32'(owner), 32'd1);
        check("burst gnt s_adr", s_adr, 32'h0000_2000);
        check("burst gnt s_we",  32'(s_we), 32'd1);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            m1_adr = 32'h0000_2000 + 32'(b * 4);
            m1_cti = burst_cti[b];
            s_ack  = 1'b1;
            #2;
            check($sformatf("burst[%0d] busy", b),  32'(busy),   32'd1);
            check($sformatf("burst[%0d] owner", b), 32'(owner),  32'd1);
            check($sformatf("burst[%0d] m1ack", b), 32'(m1_ack), 32'd1);
            check($sformatf("burst[%0d] m0ack", b), 32'(m0_ack), 32'd0);
            check($sformatf("burst[%0d] s_cti", b), 32'(s_cti),  32'(burst_cti[b]));
            check($sformatf("burst[%0d] s_adr", b), s_adr, 32'h0000_2000 + 32'(b * 4));
        end
        @(negedge clk);
        s_ack = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
        #2;
        check("burst end idle", 32'(busy), 32'd0);
        @(negedge clk); #2;
        check("burst m0 gnt busy",  32'(busy),  32'd1);
        check("burst m0 gnt owner", 32'(owner), 32'd0);
        @(negedge clk);
        s_ack = 1'b1;
        #2;
        check("burst m0 ack", 32'(m0_ack), 32'd1);
        @(negedge clk);
        s_ack = 1'b0; m0_stb = 1'b0;
        #2;
        check("burst m0 done", 32'(busy), 32'd0);

        // ---------------- timeout, slave silent ----------------
        @(negedge clk);
        m0_stb = 1'b1; m0_cti = 3'b000;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); #2;
            if (i < 8) begin
                check($sformatf("tmo cyc%0d s_stb", i), 32'(s_stb),  32'd1);
                check($sformatf("tmo cyc%0d m0ack", i), 32'(m0_ack), 32'd0);
                check($sformatf("tmo cyc%0d flag", i),  32'(tmo),    32'd0);
            end else begin
                check("tmo hit m0ack", 32'(m0_ack), 32'd1);
                check("tmo hit m1ack", 32'(m1_ack), 32'd0);
                check("tmo hit m_dat", m_dat, 32'hFFFF_FFFF);
                check("tmo hit s_stb", 32'(s_stb), 32'd0);
            end
        end
        @(negedge clk);
        m0_stb = 1'b0;
        #2;
        check("tmo release busy", 32'(busy), 32'd0);
        check("tmo flag set",     32'(tmo),  32'd1);
        @(negedge clk); #2;
        check("tmo flag sticky",  32'(tmo),  32'd1);
        @(negedge clk);
        tmo_clr = 1'b1;
        #2;
        @(negedge clk);
        tmo_clr = 1'b0;
        #2;
        check("tmo flag cleared", 32'(tmo), 32'd0);

        // Second timeout with a clear in the very cycle of the set.
        @(negedge clk);
        m0_stb = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            tmo_clr = (i == 8);
            #2;
        end
        check("tmo2 hit m0ack", 32'(m0_ack), 32'd1);
        @(negedge clk);
        tmo_clr = 1'b0; m0_stb = 1'b0;
        #2;
        check("tmo set beats clr", 32'(tmo), 32'd1);
        @(negedge clk);
        tmo_clr = 1'b1;
        @(negedge clk);
        tmo_clr = 1'b0;
        #2;
        check("tmo2 cleared", 32'(tmo), 32'd0);

        // ---------------- abort mid-burst ----------------
        @(negedge clk);
        m0_stb = 1'b1; m0_cti = 3'b010;
        @(negedge clk);
        s_ack = 1'b1;
        #2;
        check("abort beat m0ack", 32'(m0_ack), 32'd1);
        @(negedge clk);
        s_ack = 1'b0;
        #2;
        check("abort burst kept", 32'(busy), 32'd1);
        @(negedge clk);
        m0_stb = 1'b0;
        #2;
        check("abort s_stb",  32'(s_stb),  32'd0);
        check("abort no ack", 32'(m0_ack), 32'd0);
        @(negedge clk); #2;
        check("abort idle",   32'(busy),   32'd0);
        check("abort idle ack", 32'(m0_ack), 32'd0);
        m0_cti = 3'b000;

        // ---------------- reset during GNT ----------------
        @(negedge clk);
        m0_stb = 1'b1;
        @(negedge clk);
        s_ack = 1'b1;
        #2;
        check("rstmid pre s_stb", 32'(s_stb),  32'd1);
        check("rstmid pre m0ack", 32'(m0_ack), 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid s_stb", 32'(s_stb),  32'd0);
        check("rstmid m0ack", 32'(m0_ack), 32'd0);
        check("rstmid busy",  32'(busy),   32'd0);
        @(negedge clk);
        s_ack = 1'b0; m0_stb = 1'b0; rst = 1'b0;
        #2;
        check("rstmid after busy", 32'(busy), 32'd0);
        // m0 was granted last; a tie granting m0 shows last returned to 1.
        @(negedge clk);
        m0_stb = 1'b1; m1_stb = 1'b1;
        @(negedge clk); #2;
        check("rstmid tie busy",  32'(busy),  32'd1);
        check("rstmid tie owner", 32'(owner), 32'd0);
        @(negedge clk);
        m0_stb = 1'b0; m1_stb = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
